// File: rtl/axi_lite_reg_master.sv
// rtl/axi_lite_reg_master.sv - single-beat register command to AXI4-Lite master bridge
module axi_lite_reg_master #(
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_wr,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [31:0]           i_cmd_wdata,
  input  logic [3:0]            i_cmd_wstrb,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [31:0]           o_rsp_rdata,
  output logic [1:0]            o_rsp_resp,
  output logic                  o_rsp_timeout,
  output logic                  o_awvalid,
  output logic [ADDR_WIDTH-1:0] o_awaddr,
  input  logic                  i_awready,
  output logic                  o_wvalid,
  output logic [31:0]           o_wdata,
  output logic [3:0]            o_wstrb,
  input  logic                  i_wready,
  input  logic                  i_bvalid,
  output logic                  o_bready,
  input  logic [1:0]            i_bresp,
  output logic                  o_arvalid,
  output logic [ADDR_WIDTH-1:0] o_araddr,
  input  logic                  i_arready,
  input  logic                  i_rvalid,
  output logic                  o_rready,
  input  logic [1:0]            i_rresp,
  input  logic [31:0]           i_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_RESPOND
  } state_t;

  // Last counter value before the timeout fires; only meaningful when enabled.
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES > 0) ? 32'(TIMEOUT_CYCLES - 1) : 32'd0;
  localparam logic        TMO_EN   = (TIMEOUT_CYCLES > 0);

  state_t                r_state;
  state_t                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_wstrb;
  logic                  r_aw_done;
  logic                  r_w_done;
  logic [31:0]           r_cnt;
  logic [31:0]           r_rdata;
  logic [1:0]            r_resp;
  logic                  r_timeout;

  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_wait_state;
  logic                  w_tmo;
  logic                  w_tmo_fire;

  // Valids and readies come from state and completion flags only, never from the slave's readies.
  assign o_cmd_ready   = (r_state == S_IDLE);
  assign o_awvalid     = (r_state == S_WR_ADDR_DATA) && !r_aw_done;
  assign o_wvalid      = (r_state == S_WR_ADDR_DATA) && !r_w_done;
  assign o_bready      = (r_state == S_WR_RESP);
  assign o_arvalid     = (r_state == S_RD_ADDR);
  assign o_rready      = (r_state == S_RD_DATA);
  assign o_rsp_valid   = (r_state == S_RESPOND);
  assign o_awaddr      = r_addr;
  assign o_araddr      = r_addr;
  assign o_wdata       = r_wdata;
  assign o_wstrb       = r_wstrb;
  assign o_rsp_rdata   = r_rdata;
  assign o_rsp_resp    = r_resp;
  assign o_rsp_timeout = r_timeout;

  assign w_aw_hs      = o_awvalid && i_awready;
  assign w_w_hs       = o_wvalid && i_wready;
  assign w_wait_state = (r_state == S_WR_ADDR_DATA) || (r_state == S_WR_RESP) ||
                        (r_state == S_RD_ADDR) || (r_state == S_RD_DATA);
  assign w_tmo        = TMO_EN && w_wait_state && (r_cnt == TMO_LAST);

  // Next-state selection; a handshake in the final allowed cycle wins over the timeout.
  always_comb begin
    w_state_next = r_state;
    w_tmo_fire   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_cmd_valid) begin
          w_state_next = i_cmd_wr ? S_WR_ADDR_DATA : S_RD_ADDR;
        end
      end
      S_WR_ADDR_DATA: begin
        if ((r_aw_done || w_aw_hs) && (r_w_done || w_w_hs)) begin
          w_state_next = S_WR_RESP;
        end else if (w_tmo) begin
          w_state_next = S_RESPOND;
          w_tmo_fire   = 1'b1;
        end
      end
      S_WR_RESP: begin
        if (i_bvalid) begin
          w_state_next = S_RESPOND;
        end else if (w_tmo) begin
          w_state_next = S_RESPOND;
          w_tmo_fire   = 1'b1;
        end
      end
      S_RD_ADDR: begin
        if (i_arready) begin
          w_state_next = S_RD_DATA;
        end else if (w_tmo) begin
          w_state_next = S_RESPOND;
          w_tmo_fire   = 1'b1;
        end
      end
      S_RD_DATA: begin
        if (i_rvalid) begin
          w_state_next = S_RESPOND;
        end else if (w_tmo) begin
          w_state_next = S_RESPOND;
          w_tmo_fire   = 1'b1;
        end
      end
      S_RESPOND: begin
        if (i_rsp_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register, command latch, per-channel completion flags, wait counter and response capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_cnt     <= '0;
      r_rdata   <= '0;
      r_resp    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if (r_state == S_IDLE && i_cmd_valid) begin
        r_addr    <= i_cmd_addr;
        r_wdata   <= i_cmd_wdata;
        r_wstrb   <= i_cmd_wstrb;
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end else begin
        if (w_aw_hs) r_aw_done <= 1'b1;
        if (w_w_hs)  r_w_done  <= 1'b1;
      end

      if (w_state_next != r_state) begin
        r_cnt <= '0;
      end else if (w_wait_state) begin
        r_cnt <= r_cnt + 32'd1;
      end

      if (w_tmo_fire) begin
        r_rdata   <= '0;
        r_resp    <= 2'b10;
        r_timeout <= 1'b1;
      end else if (r_state == S_WR_RESP && i_bvalid) begin
        r_rdata   <= '0;
        r_resp    <= i_bresp;
        r_timeout <= 1'b0;
      end else if (r_state == S_RD_DATA && i_rvalid) begin
        r_rdata   <= i_rdata;
        r_resp    <= i_rresp;
        r_timeout <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_reg_master.sv
// tb/tb_axi_lite_reg_master.sv - scoreboard bench for axi_lite_reg_master with a memory-backed slave
module tb_axi_lite_reg_master;

  localparam int AW    = 16;
  localparam int NEVER = 100000;
  localparam int BOUND = 300;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_cmd_valid, o_cmd_ready, i_cmd_wr;
  logic [AW-1:0] i_cmd_addr;
  logic [31:0]   i_cmd_wdata;
  logic [3:0]    i_cmd_wstrb;
  logic          o_rsp_valid, i_rsp_ready;
  logic [31:0]   o_rsp_rdata;
  logic [1:0]    o_rsp_resp;
  logic          o_rsp_timeout;
  logic          o_awvalid, i_awready;
  logic [AW-1:0] o_awaddr;
  logic          o_wvalid, i_wready;
  logic [31:0]   o_wdata;
  logic [3:0]    o_wstrb;
  logic          i_bvalid, o_bready;
  logic [1:0]    i_bresp;
  logic          o_arvalid, i_arready;
  logic [AW-1:0] o_araddr;
  logic          i_rvalid, o_rready;
  logic [1:0]    i_rresp;
  logic [31:0]   i_rdata;

  always #5 clk = ~clk;

  axi_lite_reg_master #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_wr(i_cmd_wr),
    .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata), .i_cmd_wstrb(i_cmd_wstrb),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata),
    .o_rsp_resp(o_rsp_resp), .o_rsp_timeout(o_rsp_timeout),
    .o_awvalid(o_awvalid), .o_awaddr(o_awaddr), .i_awready(i_awready),
    .o_wvalid(o_wvalid), .o_wdata(o_wdata), .o_wstrb(o_wstrb), .i_wready(i_wready),
    .i_bvalid(i_bvalid), .o_bready(o_bready), .i_bresp(i_bresp),
    .o_arvalid(o_arvalid), .o_araddr(o_araddr), .i_arready(i_arready),
    .i_rvalid(i_rvalid), .o_rready(o_rready), .i_rresp(i_rresp), .i_rdata(i_rdata)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
  } rsp_t;

  rsp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  // Slave register file: word 1 is the read-only version register; 0x10 and up decode to SLVERR.
  logic [31:0] mem[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Response monitor: pops the scoreboard on every response handshake and watches stall stability.
  logic [34:0] held;
  logic        holding = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      holding = 1'b0;
    end else if (o_rsp_valid) begin
      if (holding) chk("rsp_stable", {o_rsp_timeout, o_rsp_resp, o_rsp_rdata}, held);
      chk("cmd_ready_in_respond", o_cmd_ready, 0);
      if (i_rsp_ready) begin
        holding = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got rdata %0h with empty scoreboard", o_rsp_rdata);
        end else begin
          rsp_t e;
          e = exp_q.pop_front();
          chk("rsp_rdata", o_rsp_rdata, e.rdata);
          chk("rsp_resp", o_rsp_resp, e.resp);
          chk("rsp_timeout", o_rsp_timeout, e.tmo);
        end
      end else begin
        held    = {o_rsp_timeout, o_rsp_resp, o_rsp_rdata};
        holding = 1'b1;
      end
    end
  end

  // Issue one command, push its expected response, then play the slave until the response is taken.
  task automatic run_txn(input bit wr, input logic [AW-1:0] addr, input logic [31:0] wdata,
                         input logic [3:0] wstrb, input int aw_d, input int w_d, input int b_d,
                         input int ar_d, input int r_d, input int hold, input bit tmo_exp,
                         input int max_cyc, output int lat, output int awc, output int wc,
                         output int arc, output int hc);
    rsp_t e;
    bit   aw_done = 0, w_done = 0, b_done = 0, ar_done = 0, r_done = 0, done = 0;
    bit   p_aw = 0, p_w = 0, p_b = 0, p_ar = 0, p_r = 0, p_rsp = 0;
    int   bc = 0, rc = 0;
    int   idx;
    bit   ok_addr;
    lat = -1; awc = 0; wc = 0; arc = 0; hc = 0;
    idx     = int'(addr[3:2]);
    ok_addr = (addr < 16);

    for (int k = 0; k < 50 && !o_cmd_ready; k++) begin
      @(posedge clk); #1;
    end
    chk("cmd_ready_before_issue", o_cmd_ready, 1);
    i_cmd_valid = 1; i_cmd_wr = wr; i_cmd_addr = addr; i_cmd_wdata = wdata; i_cmd_wstrb = wstrb;
    @(posedge clk); #1;
    i_cmd_valid = 0;
    chk("cmd_ready_after_accept", o_cmd_ready, 0);

    e.rdata = 0; e.resp = ok_addr ? 2'b00 : 2'b10; e.tmo = 0;
    if (tmo_exp) begin
      e.resp = 2'b10; e.tmo = 1;
    end else if (wr) begin
      if (ok_addr && idx != 1)
        for (int b = 0; b < 4; b++) if (wstrb[b]) mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else if (ok_addr) begin
      e.rdata = mem[idx];
    end
    exp_q.push_back(e);

    for (int c = 0; c < max_cyc && !done; c++) begin
      if (p_aw) aw_done = 1;
      if (p_w)  w_done  = 1;
      if (p_b)  b_done  = 1;
      if (p_ar) ar_done = 1;
      if (p_r)  r_done  = 1;
      if (o_awvalid) begin
        chk("awaddr", o_awaddr, addr);
        awc++;
      end
      i_awready = o_awvalid && (awc > aw_d);
      if (o_wvalid) begin
        chk("wdata", o_wdata, wdata);
        chk("wstrb", o_wstrb, wstrb);
        wc++;
      end
      i_wready = o_wvalid && (wc > w_d);
      if (aw_done && w_done && !b_done) bc++;
      i_bvalid = (bc > b_d) && !b_done;
      i_bresp  = ok_addr ? 2'b00 : 2'b10;
      if (o_arvalid) begin
        chk("araddr", o_araddr, addr);
        arc++;
      end
      i_arready = o_arvalid && (arc > ar_d);
      if (ar_done && !r_done) rc++;
      i_rvalid = (rc > r_d) && !r_done;
      i_rresp  = ok_addr ? 2'b00 : 2'b10;
      i_rdata  = (i_rvalid && ok_addr) ? mem[idx] : 32'h0;
      if (o_rsp_valid) begin
        if (lat < 0) lat = c + 1;
        hc++;
        i_rsp_ready = (hc > hold);
      end else begin
        i_rsp_ready = 0;
      end
      p_aw  = o_awvalid && i_awready;
      p_w   = o_wvalid && i_wready;
      p_b   = i_bvalid && o_bready;
      p_ar  = o_arvalid && i_arready;
      p_r   = i_rvalid && o_rready;
      p_rsp = o_rsp_valid && i_rsp_ready;
      @(posedge clk); #1;
      if (p_rsp) done = 1;
    end
    i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0; i_rsp_ready = 0;
    if (!done && max_cyc >= BOUND) begin
      checks++;
      errors++;
      $display("FAIL rsp_wait_bound: no response within %0d cycles for addr %0h", max_cyc, addr);
    end
  endtask

  int lat, awc, wc, arc, hc;

  initial begin
    mem[0] = 0; mem[1] = 32'h1000_0000; mem[2] = 0; mem[3] = 0;
    rst = 1; i_cmd_valid = 0; i_cmd_wr = 0; i_cmd_addr = 0; i_cmd_wdata = 0; i_cmd_wstrb = 0;
    i_rsp_ready = 0; i_awready = 0; i_wready = 0; i_bvalid = 0; i_bresp = 0;
    i_arready = 0; i_rvalid = 0; i_rresp = 0; i_rdata = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_cmd_ready", o_cmd_ready, 1);
    chk("reset_handshakes", {o_awvalid, o_wvalid, o_bready, o_arvalid, o_rready, o_rsp_valid}, 0);
    chk("reset_rsp_fields", {o_rsp_timeout, o_rsp_resp, o_rsp_rdata}, 0);
    chk("reset_axi_fields", {o_awaddr, o_araddr, o_wdata, o_wstrb}, 0);
    rst = 0;
    @(posedge clk); #1;

    run_txn(1, 16'h0000, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0, 0, 0, 0, BOUND, lat, awc, wc, arc, hc);
    chk("wr_zero_wait_latency", lat, 3);
    chk("wr_zero_wait_aw_cycles", awc, 1);
    chk("wr_zero_wait_w_cycles", wc, 1);

    run_txn(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0, BOUND, lat, awc, wc, arc, hc);
    chk("rd_zero_wait_latency", lat, 3);
    run_txn(0, 16'h0004, 0, 0, 0, 0, 0, 0, 0, 0, 0, BOUND, lat, awc, wc, arc, hc);

    run_txn(1, 16'h0008, 32'h1234_5678, 4'hF, 5, 0, 0, 0, 0, 0, 0, BOUND, lat, awc, wc, arc, hc);
    chk("slow_aw_awvalid_cycles", awc, 6);
    chk("slow_aw_wvalid_cycles", wc, 1);
    chk("slow_aw_latency", lat, 8);

    run_txn(0, 16'h0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, BOUND, lat, awc, wc, arc, hc);

    run_txn(0, 16'h000C, 0, 0, 0, 0, 0, NEVER, 0, 0, 1, BOUND, lat, awc, wc, arc, hc);
    chk("tmo_arvalid_cycles", arc, 16);
    chk("tmo_rsp_latency", lat, 17);

    run_txn(1, 16'h0008, 32'hCAFE_F00D, 4'h3, 0, 0, NEVER, 0, 0, 0, 0, 4, lat, awc, wc, arc, hc);
    chk("in_wr_resp_bready", o_bready, 1);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_bready", o_bready, 0);
    chk("rst_mid_cmd_ready", o_cmd_ready, 1);
    chk("rst_mid_valids", {o_awvalid, o_wvalid, o_arvalid, o_rready, o_rsp_valid}, 0);
    rst = 0;
    void'(exp_q.pop_back());
    run_txn(1, 16'h0008, 32'hA5A5_5A5A, 4'hF, 1, 2, 1, 0, 0, 0, 0, BOUND, lat, awc, wc, arc, hc);
    run_txn(0, 16'h0008, 0, 0, 0, 0, 0, 1, 2, 0, 0, BOUND, lat, awc, wc, arc, hc);

    run_txn(0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 10, 0, BOUND, lat, awc, wc, arc, hc);
    chk("hold_rsp_valid_cycles", hc, 11);

    for (int t = 0; t < 24; t++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, 5) * 4);
      run_txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4),
              $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3), 0, BOUND,
              lat, awc, wc, arc, hc);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
